stopwatch_ctrl: RTL and testbench

Run-control sequencer for the stopwatch counter. It turns four raw push-button inputs into clean one-cycle events, runs a four-state run/pause/lap state machine, and drives the counter's count enable, its 1 Hz tick and its clear. It also drives a display-hold level that freezes the seven-segment readout during a lap. It sits between `ui_in` and the stopwatch counter / BCD / display path in the top level.

---
 rtl/stopwatch_pkg.sv | 25 ++
 rtl/stopwatch_btn_debounce.sv | 62 ++++++
 rtl/stopwatch_ctrl.sv | 134 +++++++++++++
 tb/tb_stopwatch_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared definitions for the stopwatch run-control block.
//   state_e        - run/pause/lap FSM encoding (also driven onto the debug port)
//   EV_*           - event indices, listed from highest to lowest priority
//   is_counting()  - true in the states where the counter advances
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } state_e;

  // Event vector indices; a lower index wins when several events coincide.
  localparam int unsigned EV_CLEAR = 0;
  localparam int unsigned EV_STOP  = 1;
  localparam int unsigned EV_START = 2;
  localparam int unsigned EV_LAP   = 3;
  localparam int unsigned NUM_EV   = 4;

  function automatic logic is_counting(input state_e s);
    return (s == ST_RUN) || (s == ST_LAP);
  endfunction

endpackage

// File: rtl/stopwatch_btn_debounce.sv
// btn_debounce: conditions one raw push-button into a one-cycle press event.
//   clk, rst  - clock and asynchronous active-high reset
//   btn_raw   - raw button level, asynchronous to clk
//   btn_event - one-cycle pulse on each rising edge of the debounced level
// Path: 2-FF synchroniser -> debounce counter -> registered rising-edge detect.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 120_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_event
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             level_dly_q, level_dly_d;
  logic             event_q, event_d;

  always_comb begin
    sync1_d     = btn_raw;
    sync2_d     = sync1_q;
    cnt_d       = '0;
    level_d     = level_q;
    level_dly_d = level_q;
    // The level flips on the DEBOUNCE_CYCLES-th consecutive disagreeing cycle;
    // any agreeing cycle leaves cnt_d at zero.
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    event_d = level_q & ~level_dly_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      event_q     <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      event_q     <= event_d;
    end
  end

  assign btn_event = event_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run-control sequencer for the stopwatch counter.
//   clk, rst                     - clock, asynchronous active-high reset
//   btn_start/stop/lap/clear     - raw push buttons (asynchronous)
//   count_en                     - high in RUN and LAP
//   tick                         - one-cycle pulse every TICK_DIV counting cycles
//   clear                        - one-cycle pulse that zeroes the counter
//   hold                         - high in LAP (display freeze)
//   state                        - current FSM state for debug/LEDs
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV        = 12_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 120_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_stop,
  input  logic       btn_lap,
  input  logic       btn_clear,
  output logic       count_en,
  output logic       tick,
  output logic       clear,
  output logic       hold,
  output logic [1:0] state
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [NUM_EV-1:0] ev;
  logic [NUM_EV-1:0] btn_raw;

  assign btn_raw[EV_CLEAR] = btn_clear;
  assign btn_raw[EV_STOP]  = btn_stop;
  assign btn_raw[EV_START] = btn_start;
  assign btn_raw[EV_LAP]   = btn_lap;

  for (genvar g = 0; g < NUM_EV; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk      (clk),
      .rst      (rst),
      .btn_raw  (btn_raw[g]),
      .btn_event(ev[g])
    );
  end

  state_e           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick_q, tick_d;
  logic             clear_q, clear_d;
  logic             zero_pre;

  always_comb begin
    state_d  = state_q;
    clear_d  = 1'b0;
    zero_pre = 1'b0;
    // Each branch tests only the events legal in that state, highest priority first.
    case (state_q)
      ST_IDLE: begin
        if (ev[EV_CLEAR]) begin
          clear_d = 1'b1;
        end else if (ev[EV_START]) begin
          state_d  = ST_RUN;
          zero_pre = 1'b1;
        end
      end
      ST_RUN: begin
        if (ev[EV_STOP]) begin
          state_d = ST_PAUSE;
        end else if (ev[EV_LAP]) begin
          state_d = ST_LAP;
        end
      end
      ST_LAP: begin
        if (ev[EV_STOP]) begin
          state_d = ST_PAUSE;
        end else if (ev[EV_LAP]) begin
          state_d = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (ev[EV_CLEAR]) begin
          state_d  = ST_IDLE;
          clear_d  = 1'b1;
          zero_pre = 1'b1;
        end else if (ev[EV_START]) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The prescaler advances only when counting both before and after this edge:
  // the entry edge does not count (first tick lands TICK_DIV cycles later) and
  // the leaving edge freezes the fraction, so no tick can coincide with stop.
  always_comb begin
    pre_d  = pre_q;
    tick_d = 1'b0;
    if (zero_pre) begin
      pre_d = '0;
    end else if (is_counting(state_q) && is_counting(state_d)) begin
      if (pre_q == PRE_W'(TICK_DIV - 1)) begin
        pre_d  = '0;
        tick_d = 1'b1;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pre_q   <= '0;
      tick_q  <= 1'b0;
      clear_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      tick_q  <= tick_d;
      clear_q <= clear_d;
    end
  end

  assign count_en = is_counting(state_q);
  assign hold     = (state_q == ST_LAP);
  assign tick     = tick_q;
  assign clear    = clear_q;
  assign state    = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl (TICK_DIV=10, DEBOUNCE_CYCLES=4).
module tb_stopwatch_ctrl;

  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2, S_LAP = 2'd3;
  // Button mask bits: [0] start, [1] stop, [2] lap, [3] clear
  localparam logic [3:0] B_S = 4'b0001, B_P = 4'b0010, B_L = 4'b0100, B_C = 4'b1000;

  logic clk, rst, btn_start, btn_stop, btn_lap, btn_clear;
  logic count_en, tick, clear, hold;
  logic [1:0] state;

  stopwatch_ctrl #(.TICK_DIV(10), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .btn_start(btn_start), .btn_stop(btn_stop),
    .btn_lap(btn_lap), .btn_clear(btn_clear), .count_en(count_en),
    .tick(tick), .clear(clear), .hold(hold), .state(state)
  );

  typedef struct { int cyc; logic [1:0] st; logic cen; logic hld; logic clr; } exp_t;
  typedef struct { logic [3:0] btn; logic [1:0] st; logic cen; logic hld; logic clr; } vec_t;

  exp_t sb[$];
  int   tq[$];
  vec_t vecs[25];
  int   n_tests = 0, n_fail = 0;
  int   cyc = 0, clr_cnt = 0;
  bit   tick_chk = 0;

  initial begin clk = 0; forever #5 clk = ~clk; end
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic drive(input logic [3:0] b);
    btn_start = b[0]; btn_stop = b[1]; btn_lap = b[2]; btn_clear = b[3];
  endtask

  task automatic press(input logic [3:0] b);
    drive(b);
    repeat (6) @(negedge clk);
    drive(4'b0000);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic expect_at(input int c, input logic [1:0] st, input logic cen,
                           input logic hld, input logic clr);
    exp_t e;
    e.cyc = c; e.st = st; e.cen = cen; e.hld = hld; e.clr = clr;
    sb.push_back(e);
  endtask

  // Scoreboard consumer: state/output expectations and tick timing.
  always @(negedge clk) begin
    exp_t e;
    int   exp_c;
    if (clear === 1'b1) clr_cnt++;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      n_tests++; n_fail++;
      $display("FAIL sb_missed: got cycle %0d expected check at %0d", cyc, sb[0].cyc);
      void'(sb.pop_front());
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      chk($sformatf("c%0d state", cyc), state, e.st);
      chk($sformatf("c%0d count_en", cyc), count_en, e.cen);
      chk($sformatf("c%0d hold", cyc), hold, e.hld);
      chk($sformatf("c%0d clear", cyc), clear, e.clr);
    end
    if (tick_chk) begin
      while (tq.size() > 0 && tq[0] < cyc) begin
        n_tests++; n_fail++;
        $display("FAIL tick_missing: got no tick by %0d expected tick at %0d", cyc, tq[0]);
        void'(tq.pop_front());
      end
      if (tick === 1'b1) begin
        exp_c = (tq.size() > 0) ? tq[0] : -1;
        if (exp_c == cyc) void'(tq.pop_front());
        chk("tick_cycle", cyc, exp_c);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int c0, p0, q0, r0, n0;
    logic [1:0] pst;
    logic pcen, phld;

    vecs[0]  = '{B_S,       S_RUN,   1, 0, 0};
    vecs[1]  = '{B_L,       S_LAP,   1, 1, 0};
    vecs[2]  = '{B_L,       S_RUN,   1, 0, 0};
    vecs[3]  = '{B_L,       S_LAP,   1, 1, 0};
    vecs[4]  = '{B_P,       S_PAUSE, 0, 0, 0};
    vecs[5]  = '{B_L,       S_PAUSE, 0, 0, 0};
    vecs[6]  = '{B_P,       S_PAUSE, 0, 0, 0};
    vecs[7]  = '{B_S,       S_RUN,   1, 0, 0};
    vecs[8]  = '{B_C,       S_RUN,   1, 0, 0};
    vecs[9]  = '{B_S,       S_RUN,   1, 0, 0};
    vecs[10] = '{B_P,       S_PAUSE, 0, 0, 0};
    vecs[11] = '{B_C|B_S,   S_IDLE,  0, 0, 1};
    vecs[12] = '{B_C,       S_IDLE,  0, 0, 1};
    vecs[13] = '{B_P|B_L,   S_IDLE,  0, 0, 0};
    vecs[14] = '{B_S|B_L,   S_RUN,   1, 0, 0};
    vecs[15] = '{B_P|B_L,   S_PAUSE, 0, 0, 0};
    vecs[16] = '{B_S,       S_RUN,   1, 0, 0};
    vecs[17] = '{B_P|B_L|B_S, S_PAUSE, 0, 0, 0};
    vecs[18] = '{B_C,       S_IDLE,  0, 0, 1};
    vecs[19] = '{B_S,       S_RUN,   1, 0, 0};
    vecs[20] = '{B_L,       S_LAP,   1, 1, 0};
    vecs[21] = '{B_S|B_L,   S_RUN,   1, 0, 0};
    vecs[22] = '{B_L,       S_LAP,   1, 1, 0};
    vecs[23] = '{B_P|B_L,   S_PAUSE, 0, 0, 0};
    vecs[24] = '{B_C,       S_IDLE,  0, 0, 1};

    drive(4'b0000);
    rst = 0;
    #2 rst = 1;
    #1;
    chk("rst state", state, S_IDLE);
    chk("rst count_en", count_en, 0);
    chk("rst hold", hold, 0);
    chk("rst tick", tick, 0);
    chk("rst clear", clear, 0);
    repeat (3) @(negedge clk);
    rst = 0;

    // Bounce rejection: 2-cycle pulses never survive a 4-cycle debounce.
    n0 = clr_cnt;
    for (int i = 0; i < 3; i++) begin
      btn_start = 1; repeat (2) @(negedge clk);
      btn_start = 0; repeat (2) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    chk("bounce state", state, S_IDLE);
    chk("bounce count_en", count_en, 0);
    chk("bounce clears", clr_cnt - n0, 0);

    // Start, pause at prescaler 6, resume, pause, clear+start, restart.
    tick_chk = 1;
    c0 = cyc;
    expect_at(c0 + 7, S_IDLE, 0, 0, 0);
    expect_at(c0 + 8, S_RUN, 1, 0, 0);
    expect_at(c0 + 9, S_RUN, 1, 0, 0);
    tq.push_back(c0 + 18);
    press(B_S);
    wait_until(c0 + 17);
    expect_at(c0 + 24, S_RUN, 1, 0, 0);
    expect_at(c0 + 25, S_PAUSE, 0, 0, 0);
    press(B_P);
    wait_until(c0 + 45);
    p0 = cyc;
    expect_at(p0 + 7, S_PAUSE, 0, 0, 0);
    expect_at(p0 + 8, S_RUN, 1, 0, 0);
    tq.push_back(p0 + 12);
    tq.push_back(p0 + 22);
    press(B_S);
    wait_until(p0 + 20);
    expect_at(p0 + 28, S_PAUSE, 0, 0, 0);
    press(B_P);
    wait_until(p0 + 45);
    q0 = cyc;
    expect_at(q0 + 7, S_PAUSE, 0, 0, 0);
    expect_at(q0 + 8, S_IDLE, 0, 0, 1);
    expect_at(q0 + 9, S_IDLE, 0, 0, 0);
    press(B_C | B_S);
    wait_until(q0 + 20);
    r0 = cyc;
    expect_at(r0 + 8, S_RUN, 1, 0, 0);
    tq.push_back(r0 + 18);
    press(B_S);
    wait_until(r0 + 20);
    expect_at(r0 + 28, S_PAUSE, 0, 0, 0);
    press(B_P);
    wait_until(r0 + 40);
    expect_at(r0 + 48, S_IDLE, 0, 0, 1);
    expect_at(r0 + 49, S_IDLE, 0, 0, 0);
    press(B_C);
    wait_until(r0 + 60);

    // Lap sequence; stop lands with the prescaler at 9, so resume ticks after 1 cycle.
    c0 = cyc;
    expect_at(c0 + 8, S_RUN, 1, 0, 0);
    for (int k = 0; k < 7; k++) tq.push_back(c0 + 18 + 10 * k);
    press(B_S);
    wait_until(c0 + 20);
    expect_at(c0 + 27, S_RUN, 1, 0, 0);
    expect_at(c0 + 28, S_LAP, 1, 1, 0);
    press(B_L);
    wait_until(c0 + 40);
    expect_at(c0 + 48, S_RUN, 1, 0, 0);
    press(B_L);
    wait_until(c0 + 60);
    expect_at(c0 + 68, S_LAP, 1, 1, 0);
    press(B_L);
    wait_until(c0 + 80);
    expect_at(c0 + 87, S_LAP, 1, 1, 0);
    expect_at(c0 + 88, S_PAUSE, 0, 0, 0);
    press(B_P);
    wait_until(c0 + 100);
    expect_at(c0 + 108, S_RUN, 1, 0, 0);
    tq.push_back(c0 + 109);
    tq.push_back(c0 + 119);
    press(B_S);
    wait_until(c0 + 125);
    chk("tick queue drained", tq.size(), 0);
    chk("sb drained", sb.size(), 0);

    // Reset mid-run with random buttons, then clear held through release.
    tick_chk = 0;
    tq.delete();
    @(negedge clk);
    #2 rst = 1;
    drive(4'($urandom_range(0, 15)));
    #1;
    chk("midrst state", state, S_IDLE);
    chk("midrst count_en", count_en, 0);
    chk("midrst hold", hold, 0);
    chk("midrst tick", tick, 0);
    chk("midrst clear", clear, 0);
    repeat (3) @(negedge clk);
    rst = 0;
    n0 = clr_cnt;
    drive(B_C);
    repeat (40) @(negedge clk);
    drive(4'b0000);
    repeat (12) @(negedge clk);
    chk("held clear events", clr_cnt - n0, 1);
    chk("held clear state", state, S_IDLE);

    // Table-driven event/priority walk.
    pst = S_IDLE; pcen = 0; phld = 0;
    for (int i = 0; i < 25; i++) begin
      c0 = cyc;
      expect_at(c0 + 7, pst, pcen, phld, 0);
      expect_at(c0 + 8, vecs[i].st, vecs[i].cen, vecs[i].hld, vecs[i].clr);
      expect_at(c0 + 9, vecs[i].st, vecs[i].cen, vecs[i].hld, 0);
      press(vecs[i].btn);
      wait_until(c0 + 14);
      pst = vecs[i].st; pcen = vecs[i].cen; phld = vecs[i].hld;
    end
    repeat (5) @(negedge clk);
    chk("final sb drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
